// File: rtl/bcd_unpack.sv
// bcd_unpack: 10-bit binary to three BCD display digits using a shift-and-add-3 loop, one bit per clock.
// Latency: 11 clocks from the accepting start edge to valid digits. done pulses for one cycle. One conversion per 12 clocks.
// Backpressure: none. start is ignored while busy. clear aborts the conversion and blanks the digits. Optional macro BCD_UNPACK_BLANK_LZ_EN.
module bcd_unpack (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] value,
  input  logic       start,
  input  logic       clear,
  output logic [3:0] bcd1,
  output logic [3:0] bcd10,
  output logic [3:0] bcd100,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam logic [3:0] DIG_BLANK = 4'b1010;
  localparam logic [3:0] DIG_ERR   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_shift;
  logic [11:0] r_scratch;
  logic [3:0]  r_cnt;
  logic        r_ovf_pend;
  logic [3:0]  r_bcd1;
  logic [3:0]  r_bcd10;
  logic [3:0]  r_bcd100;
  logic        r_busy;
  logic        r_done;
  logic        r_overflow;

  logic [11:0] w_adj;
  logic [3:0]  w_dig1;
  logic [3:0]  w_dig10;
  logic [3:0]  w_dig100;

  // Add 3 to every scratch nibble that is 5 or more, ahead of the shift.
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < 3; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // Final display digits from the scratch register, with optional leading-zero blanking.
  always_comb begin
    w_dig1   = r_scratch[3:0];
    w_dig10  = r_scratch[7:4];
    w_dig100 = r_scratch[11:8];
`ifdef BCD_UNPACK_BLANK_LZ_EN
    if (r_scratch[11:8] == 4'd0) begin
      w_dig100 = DIG_BLANK;
      if (r_scratch[7:4] == 4'd0) begin
        w_dig10 = DIG_BLANK;
      end
    end
`else
    // All three digits are always shown as 0-9.
`endif
  end

  // Conversion FSM: clear has priority, then the IDLE/SHIFT/FINISH sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd1     <= DIG_BLANK;
      r_bcd10    <= DIG_BLANK;
      r_bcd100   <= DIG_BLANK;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd1     <= DIG_BLANK;
      r_bcd10    <= DIG_BLANK;
      r_bcd100   <= DIG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift    <= value;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (value > 10'd999);
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          {r_scratch, r_shift} <= {w_adj[10:0], r_shift, 1'b0};
          r_cnt <= r_cnt + 4'd1;
          // The tenth shift is happening now, so the next cycle is FINISH.
          if (r_cnt == 4'd9) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          if (r_ovf_pend) begin
            r_bcd1   <= DIG_ERR;
            r_bcd10  <= DIG_ERR;
            r_bcd100 <= DIG_ERR;
          end else begin
            r_bcd1   <= w_dig1;
            r_bcd10  <= w_dig10;
            r_bcd100 <= w_dig100;
          end
          r_overflow <= r_ovf_pend;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd1     = r_bcd1;
  assign bcd10    = r_bcd10;
  assign bcd100   = r_bcd100;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_unpack.sv
// tb_bcd_unpack: directed checks of the binary-to-BCD converter.
// Covers reset, conversions, leading-zero coding, overflow, back-to-back start and clear abort.
// Expected digits are hand-computed for the build selected by BCD_UNPACK_BLANK_LZ_EN.
module tb_bcd_unpack;

  logic       clock;
  logic       reset_n;
  logic [9:0] value;
  logic       start;
  logic       clear;
  logic [3:0] bcd1;
  logic [3:0] bcd10;
  logic [3:0] bcd100;
  logic       busy;
  logic       done;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] BL = 4'b1010;
  localparam logic [3:0] ER = 4'b1111;

`ifdef BCD_UNPACK_BLANK_LZ_EN
  localparam logic [11:0] EXP_0  = {BL, BL, 4'd0};
  localparam logic [11:0] EXP_5  = {BL, BL, 4'd5};
  localparam logic [11:0] EXP_40 = {BL, 4'd4, 4'd0};
`else
  localparam logic [11:0] EXP_0  = {4'd0, 4'd0, 4'd0};
  localparam logic [11:0] EXP_5  = {4'd0, 4'd0, 4'd5};
  localparam logic [11:0] EXP_40 = {4'd0, 4'd4, 4'd0};
`endif

  bcd_unpack dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .value    (value),
    .start    (start),
    .clear    (clear),
    .bcd1     (bcd1),
    .bcd10    (bcd10),
    .bcd100   (bcd100),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one start pulse and wait for done. lat is -1 if done never arrives.
  // bad counts busy/done protocol violations seen along the way.
  task automatic do_conv(input logic [9:0] v, output int lat, output logic [12:0] res,
                         output int bad);
    lat = -1;
    bad = 0;
    res = '0;
    @(negedge clock);
    value = v;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (busy !== 1'b1) bad++;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        lat = i;
        res = {bcd100, bcd10, bcd1, overflow};
        if (busy !== 1'b0) bad++;
        @(negedge clock);
        if (done !== 1'b0) bad++;
        break;
      end else if (busy !== 1'b1) begin
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    int bad;
    logic [12:0] res;
    reset_n = 1'b1;
    value = '0;
    start = 1'b0;
    clear = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({bcd100, bcd10, bcd1, busy, done, overflow} !== {BL, BL, BL, 3'b000}) begin
      n_err++;
      $display("FAIL reset_initial: got %h/%h/%h b%b d%b o%b, want a/a/a b0 d0 o0",
               bcd100, bcd10, bcd1, busy, done, overflow);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    // Start a conversion and pull reset in the middle of SHIFT, between clock edges.
    @(negedge clock);
    value = 10'd987;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_busy: got busy=%b, want 1", busy);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bcd100, bcd10, bcd1, busy, done, overflow} !== {BL, BL, BL, 3'b000}) begin
      n_err++;
      $display("FAIL reset_async: got %h/%h/%h b%b d%b o%b, want a/a/a b0 d0 o0",
               bcd100, bcd10, bcd1, busy, done, overflow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    do_conv(10'd0, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {EXP_0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_then_zero: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {EXP_0, 1'b0});
    end
  endtask

  task automatic test_convert();
    int lat;
    int bad;
    logic [12:0] res;
    do_conv(10'd987, lat, res, bad);
    n_cmp++;
    if (lat !== 11) begin
      n_err++;
      $display("FAIL conv987_latency: got %0d, want 11", lat);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL conv987_handshake: got %0d violations, want 0", bad);
    end
    n_cmp++;
    if (res !== {4'd9, 4'd8, 4'd7, 1'b0}) begin
      n_err++;
      $display("FAIL conv987_digits: got %h, want %h", res, {4'd9, 4'd8, 4'd7, 1'b0});
    end
  endtask

  task automatic test_leading_zero();
    int lat;
    int bad;
    logic [12:0] res;
    do_conv(10'd5, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {EXP_5, 1'b0}) begin
      n_err++;
      $display("FAIL lz_5: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {EXP_5, 1'b0});
    end
    do_conv(10'd40, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {EXP_40, 1'b0}) begin
      n_err++;
      $display("FAIL lz_40: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {EXP_40, 1'b0});
    end
    do_conv(10'd999, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {4'd9, 4'd9, 4'd9, 1'b0}) begin
      n_err++;
      $display("FAIL conv999: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {4'd9, 4'd9, 4'd9, 1'b0});
    end
  endtask

  task automatic test_overflow();
    int lat;
    int bad;
    logic [12:0] res;
    do_conv(10'd1023, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {ER, ER, ER, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_1023: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {ER, ER, ER, 1'b1});
    end
    repeat (4) @(negedge clock);
    n_cmp++;
    if ({bcd100, bcd10, bcd1, overflow} !== {ER, ER, ER, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_hold: got %h/%h/%h o%b, want f/f/f o1", bcd100, bcd10, bcd1, overflow);
    end
    do_conv(10'd1000, lat, res, bad);
    n_cmp++;
    if (res !== {ER, ER, ER, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_1000: got %h, want %h", res, {ER, ER, ER, 1'b1});
    end
    do_conv(10'd100, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {4'd1, 4'd0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_then_100: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {4'd1, 4'd0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int t_done[2];
    logic [11:0] d_done[2];
    n_done = 0;
    t_done[0] = -1;
    t_done[1] = -1;
    d_done[0] = '0;
    d_done[1] = '0;
    @(negedge clock);
    value = 10'd321;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 3) value = 10'd654;
      if (done === 1'b1) begin
        if (n_done < 2) begin
          t_done[n_done] = i;
          d_done[n_done] = {bcd100, bcd10, bcd1};
        end
        n_done++;
      end
      if (i == 12) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_gap_busy: got busy=%b, want 0", busy);
        end
      end
      if (i == 13) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_reaccept: got busy=%b, want 1", busy);
        end
        start = 1'b0;
      end
    end
    n_cmp++;
    if (n_done !== 2 || t_done[0] !== 12 || t_done[1] !== 24) begin
      n_err++;
      $display("FAIL b2b_timing: got %0d pulses at %0d,%0d, want 2 pulses at 12,24",
               n_done, t_done[0], t_done[1]);
    end
    n_cmp++;
    if (d_done[0] !== {4'd3, 4'd2, 4'd1} || d_done[1] !== {4'd6, 4'd5, 4'd4}) begin
      n_err++;
      $display("FAIL b2b_digits: got %h,%h, want 321,654", d_done[0], d_done[1]);
    end
  endtask

  task automatic test_clear();
    int lat;
    int bad;
    int n_done;
    logic [12:0] res;
    do_conv(10'd1023, lat, res, bad);
    @(negedge clock);
    value = 10'd777;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({bcd100, bcd10, bcd1, busy, done, overflow} !== {BL, BL, BL, 3'b000}) begin
      n_err++;
      $display("FAIL clear_state: got %h/%h/%h b%b d%b o%b, want a/a/a b0 d0 o0",
               bcd100, bcd10, bcd1, busy, done, overflow);
    end
    clear = 1'b0;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL clear_quiet: got %0d busy/done cycles, want 0", n_done);
    end
    do_conv(10'd246, lat, res, bad);
    n_cmp++;
    if (lat !== 11 || bad !== 0 || res !== {4'd2, 4'd4, 4'd6, 1'b0}) begin
      n_err++;
      $display("FAIL clear_then_246: got lat=%0d bad=%0d res=%h, want lat=11 bad=0 res=%h",
               lat, bad, res, {4'd2, 4'd4, 4'd6, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_leading_zero();
    test_overflow();
    test_back_to_back();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
